// File: rtl/cpu_test_sequencer_if.sv
// CPU-facing bus of the test sequencer: register-file clear port, PC hold and memory read port.
// The sequencer drives through the master modport; the CPU/memory side uses slave.
interface cpu_test_sequencer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned MA_W  = 32
) ();
    logic             rf_we;
    logic [RA_W-1:0]  rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic             pc_hold;
    logic             mem_re;
    logic [MA_W-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output rf_we, rf_waddr, rf_wdata, pc_hold, mem_re, mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  rf_we, rf_waddr, rf_wdata, pc_hold, mem_re, mem_addr,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_test_sequencer.sv
// Test sequencer: clear the CPU register file, run the CPU for a cycle budget, then check memory.
// Define CPU_SEQ_HALT_EN to add a cpu_halt input that ends the run phase early.
module cpu_test_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REGS  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned MA_W  = 32,
    parameter int unsigned NCHK  = 2,
    localparam int unsigned FI_W = $clog2(NCHK) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           run_cycles,
    input  logic [NCHK*MA_W-1:0]  chk_addr,
    input  logic [NCHK*WIDTH-1:0] chk_data,
`ifdef CPU_SEQ_HALT_EN
    input  logic                  cpu_halt,
`endif
    cpu_test_sequencer_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [FI_W-1:0]       fail_idx
);

    typedef enum logic [2:0] {StIdle, StClear, StRun, StCheck, StDone} state_e;

    state_e                state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [31:0]           run_q, run_d;
    logic [NCHK*MA_W-1:0]  addr_q, addr_d;
    logic [NCHK*WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [FI_W-1:0]       fail_q, fail_d;
    logic                  halt;

`ifdef CPU_SEQ_HALT_EN
    assign halt = cpu_halt;
`else
    assign halt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;

        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        bus.pc_hold  = 1'b1;
        bus.mem_re   = 1'b0;
        bus.mem_addr = '0;
        busy         = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    run_d   = run_cycles;
                    addr_d  = chk_addr;
                    data_d  = chk_data;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = FI_W'(NCHK);
                    cnt_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                busy         = 1'b1;
                bus.rf_we    = 1'b1;
                bus.rf_waddr = RA_W'(cnt_q + 32'd1);
                if (cnt_q == 32'(REGS - 2)) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StRun: begin
                busy        = 1'b1;
                bus.pc_hold = 1'b0;
                // A zero budget still spends one cycle in RUN.
                if (halt || run_q == 32'd0 || cnt_q == run_q - 32'd1) begin
                    cnt_d   = '0;
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StCheck: begin
                busy = 1'b1;
                // Read k is issued at count k; its data is compared at count k+1.
                for (int k = 0; k < int'(NCHK); k++) begin
                    if (cnt_q == 32'(k)) begin
                        bus.mem_re   = 1'b1;
                        bus.mem_addr = addr_q[k*MA_W +: MA_W];
                    end
                    if (cnt_q == 32'(k + 1) &&
                        bus.mem_rdata != data_q[k*WIDTH +: WIDTH] &&
                        fail_q == FI_W'(NCHK)) begin
                        fail_d = FI_W'(k);
                    end
                end
                if (cnt_q == 32'(NCHK)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    pass_d  = (fail_d == FI_W'(NCHK));
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            run_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= FI_W'(NCHK);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_idx = fail_q;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Self-checking bench for cpu_test_sequencer: directed scenarios plus randomized sequences
// against a reference model; covers the CPU_SEQ_HALT_EN build when that macro is defined.
module tb_cpu_test_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned REGS  = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned MA_W  = 32;
    localparam int unsigned NCHK  = 2;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic [31:0]           run_cycles = '0;
    logic [NCHK*MA_W-1:0]  chk_addr = '0;
    logic [NCHK*WIDTH-1:0] chk_data = '0;
`ifdef CPU_SEQ_HALT_EN
    logic                  cpu_halt = 1'b0;
`endif
    logic                  busy, done, pass;
    logic [1:0]            fail_idx;

    cpu_test_sequencer_if #(.WIDTH(WIDTH), .RA_W(RA_W), .MA_W(MA_W)) bus ();

    cpu_test_sequencer #(
        .WIDTH(WIDTH), .REGS(REGS), .RA_W(RA_W), .MA_W(MA_W), .NCHK(NCHK)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .run_cycles (run_cycles),
        .chk_addr   (chk_addr),
        .chk_data   (chk_data),
`ifdef CPU_SEQ_HALT_EN
        .cpu_halt   (cpu_halt),
`endif
        .bus        (bus.master),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_idx   (fail_idx)
    );

    always #5 clk = ~clk;

    // Memory with exactly one cycle of read latency.
    logic [WIDTH-1:0] mem [logic [MA_W-1:0]];

    function automatic logic [WIDTH-1:0] mem_rd(input logic [MA_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    always @(posedge clk) bus.mem_rdata <= bus.mem_re ? mem_rd(bus.mem_addr) : 32'hdead_beef;

    int n_chk = 0;
    int n_fail = 0;

    // Observations gathered over one sequence.
    int               o_we, o_run, o_busy, o_err;
    bit               o_timeout;
    logic [MA_W-1:0]  o_rd[$];

    // Pulse start with the current chk_*/run_cycles, then watch until done.
    task automatic run_seq(input logic [31:0] rc, input bit mid_start, input int halt_at);
        logic [NCHK*MA_W-1:0]  sv_addr;
        logic [NCHK*WIDTH-1:0] sv_data;
        int bound;
        bit found;
        sv_addr = chk_addr;
        sv_data = chk_data;
        o_we = 0; o_run = 0; o_busy = 0; o_err = 0; o_timeout = 0; found = 0;
        o_rd.delete();
        bound = int'(REGS) + int'(rc) + int'(NCHK) + 20;
        @(negedge clk);
        run_cycles = rc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Inputs must have been latched; scramble them for the rest of the sequence.
        run_cycles = $urandom;
        chk_addr = {$urandom, $urandom};
        chk_data = {$urandom, $urandom};
        for (int c = 0; c < bound; c++) begin
            if (c > 0) @(negedge clk);
            start = 1'b0;
`ifdef CPU_SEQ_HALT_EN
            cpu_halt = 1'b0;
`endif
            if (done) begin
                found = 1;
                if (busy) o_err++;
                break;
            end
            if (busy) o_busy++;
            if (bus.rf_wdata != '0) o_err++;
            if (bus.rf_we) begin
                o_we++;
                if (bus.rf_waddr != RA_W'(o_we) || o_run > 0 || o_rd.size() > 0) o_err++;
            end else if (bus.rf_waddr != '0) begin
                o_err++;
            end
            if (bus.mem_re) o_rd.push_back(bus.mem_addr);
            else if (bus.mem_addr != '0) o_err++;
            if (!bus.pc_hold) begin
                o_run++;
                if (!busy || bus.rf_we || bus.mem_re) o_err++;
                if (mid_start && o_run == 3) start = 1'b1;
`ifdef CPU_SEQ_HALT_EN
                if (halt_at > 0 && o_run == halt_at) cpu_halt = 1'b1;
`endif
            end
        end
        if (!found) o_timeout = 1;
        chk_addr = sv_addr;
        chk_data = sv_data;
    endtask

    task automatic test_reset();
        int act;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, done, pass, bus.rf_we, bus.mem_re} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/pass/rf_we/mem_re=%b required 00000",
                     {busy, done, pass, bus.rf_we, bus.mem_re});
        end
        n_chk++;
        if (bus.pc_hold !== 1'b1 || fail_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_outputs: pc_hold=%b fail_idx=%0d required 1,2", bus.pc_hold, fail_idx);
        end
        n_chk++;
        if (bus.rf_waddr !== '0 || bus.mem_addr !== '0 || bus.rf_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_addrs: rf_waddr=%0h mem_addr=%0h rf_wdata=%0h required 0",
                     bus.rf_waddr, bus.mem_addr, bus.rf_wdata);
        end
        reset_n = 1'b1;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rf_we || bus.mem_re || busy || !bus.pc_hold) act++;
        end
        n_chk++;
        if (act != 0) begin
            n_fail++;
            $display("FAIL idle_no_activity: active cycles=%0d required 0", act);
        end
    endtask

    task automatic test_pass();
        int stable;
        mem.delete();
        mem[32'h2000] = 32'd3;
        mem[32'h2004] = 32'd5;
        chk_addr = {32'h2004, 32'h2000};
        chk_data = {32'd5, 32'd3};
        run_seq(32'd10, 0, 0);
        n_chk++;
        if (o_timeout) begin n_fail++; $display("FAIL pass_timeout: done never seen, required done=1"); end
        n_chk++;
        if (o_we != 31) begin n_fail++; $display("FAIL clear_len: rf_we cycles=%0d required 31", o_we); end
        n_chk++;
        if (o_run != 10) begin n_fail++; $display("FAIL run_len: pc_hold low cycles=%0d required 10", o_run); end
        n_chk++;
        if (o_busy != 44) begin n_fail++; $display("FAIL busy_len: busy cycles=%0d required 44", o_busy); end
        n_chk++;
        if (o_err != 0) begin n_fail++; $display("FAIL pass_protocol: violations=%0d required 0", o_err); end
        n_chk++;
        if (o_rd.size() != 2 || o_rd[0] !== 32'h2000 || o_rd[1] !== 32'h2004) begin
            n_fail++;
            $display("FAIL read_order: reads=%p required 2000,2004", o_rd);
        end
        n_chk++;
        if ({done, pass, fail_idx} !== 4'b1110) begin
            n_fail++;
            $display("FAIL pass_result: done=%b pass=%b fail_idx=%0d required 1,1,2", done, pass, fail_idx);
        end
        stable = 0;
        repeat (8) begin
            @(negedge clk);
            if ({done, pass, fail_idx} !== 4'b1110 || busy || !bus.pc_hold || bus.rf_we || bus.mem_re)
                stable++;
        end
        n_chk++;
        if (stable != 0) begin n_fail++; $display("FAIL done_hold: changed cycles=%0d required 0", stable); end
    endtask

    task automatic test_mismatch();
        mem.delete();
        mem[32'h2000] = 32'd4;
        mem[32'h2004] = 32'd6;
        chk_addr = {32'h2004, 32'h2000};
        chk_data = {32'd5, 32'd3};
        run_seq(32'd10, 0, 0);
        n_chk++;
        if (o_timeout || {done, pass, fail_idx} !== 4'b1000) begin
            n_fail++;
            $display("FAIL mismatch_result: timeout=%0d done=%b pass=%b fail_idx=%0d required 0,1,0,0",
                     o_timeout, done, pass, fail_idx);
        end
        // Only channel 1 wrong: first failing index is 1.
        mem[32'h2000] = 32'd3;
        run_seq(32'd0, 0, 0);
        n_chk++;
        if (o_timeout || {done, pass, fail_idx} !== 4'b1001) begin
            n_fail++;
            $display("FAIL mismatch_ch1: timeout=%0d done=%b pass=%b fail_idx=%0d required 0,1,0,1",
                     o_timeout, done, pass, fail_idx);
        end
        n_chk++;
        if (o_run != 1) begin n_fail++; $display("FAIL run_zero: RUN cycles=%0d required 1", o_run); end
    endtask

    task automatic test_start_during_run();
        mem.delete();
        mem[32'h2000] = 32'd3;
        mem[32'h2004] = 32'd5;
        chk_addr = {32'h2004, 32'h2000};
        chk_data = {32'd5, 32'd3};
        run_seq(32'd10, 1, 0);
        n_chk++;
        if (o_timeout || o_busy != 44 || o_run != 10 || o_we != 31) begin
            n_fail++;
            $display("FAIL start_in_run: timeout=%0d busy=%0d run=%0d we=%0d required 0,44,10,31",
                     o_timeout, o_busy, o_run, o_we);
        end
        n_chk++;
        if (pass !== 1'b1 || fail_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL start_in_run_result: pass=%b fail_idx=%0d required 1,2", pass, fail_idx);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit hit;
        int act;
        hit = 0;
        @(negedge clk);
        run_cycles = 32'd10;
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.rf_we && bus.rf_waddr == 5'd7) begin hit = 1; break; end
        end
        n_chk++;
        if (!hit) begin n_fail++; $display("FAIL reach_waddr7: not reached within 20 cycles, required reached"); end
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (bus.rf_we !== 1'b0 || busy !== 1'b0 || bus.pc_hold !== 1'b1 || bus.rf_waddr !== '0) begin
            n_fail++;
            $display("FAIL async_reset: rf_we=%b busy=%b pc_hold=%b rf_waddr=%0d required 0,0,1,0",
                     bus.rf_we, busy, bus.pc_hold, bus.rf_waddr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        act = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rf_we || bus.mem_re || busy || done) act++;
        end
        n_chk++;
        if (act != 0) begin n_fail++; $display("FAIL post_reset_idle: active cycles=%0d required 0", act); end
    endtask

    task automatic test_random();
        logic [MA_W-1:0]  a [NCHK];
        logic [WIDTH-1:0] d [NCHK];
        logic [31:0] rc;
        int exp_fail;
        for (int it = 0; it < 10; it++) begin
            mem.delete();
            rc = 32'($urandom_range(0, 40));
            for (int k = 0; k < int'(NCHK); k++) begin
                a[k] = {$urandom_range(0, 15), 2'b00};
                d[k] = $urandom;
                mem[a[k]] = ($urandom_range(0, 1) == 1) ? d[k] : d[k] ^ (32'h1 << $urandom_range(0, 31));
            end
            chk_addr = {a[1], a[0]};
            chk_data = {d[1], d[0]};
            exp_fail = NCHK;
            for (int k = int'(NCHK) - 1; k >= 0; k--)
                if (mem_rd(a[k]) != d[k]) exp_fail = k;
            run_seq(rc, 0, 0);
            n_chk++;
            if (o_timeout || o_err != 0) begin
                n_fail++;
                $display("FAIL rand_protocol[%0d]: timeout=%0d violations=%0d required 0,0", it, o_timeout, o_err);
            end
            n_chk++;
            if (o_run != ((rc == 0) ? 1 : int'(rc)) || o_busy != 31 + o_run + 3) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: rc=%0d run=%0d busy=%0d", it, rc, o_run, o_busy);
            end
            n_chk++;
            if (o_rd.size() != 2 || o_rd[0] !== a[0] || o_rd[1] !== a[1]) begin
                n_fail++;
                $display("FAIL rand_reads[%0d]: reads=%p required %0h,%0h", it, o_rd, a[0], a[1]);
            end
            n_chk++;
            if (done !== 1'b1 || pass !== (exp_fail == int'(NCHK)) || fail_idx !== 2'(exp_fail)) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: done=%b pass=%b fail_idx=%0d required 1,%0d,%0d",
                         it, done, pass, fail_idx, exp_fail == int'(NCHK), exp_fail);
            end
        end
    endtask

    task automatic test_long_run();
        int exp_run;
        mem.delete();
        mem[32'h100] = 32'd9;
        chk_addr = {32'h100, 32'h100};
        chk_data = {32'd9, 32'd9};
`ifdef CPU_SEQ_HALT_EN
        run_seq(32'd1000, 0, 20);
        exp_run = 20;
`else
        run_seq(32'd1000, 0, 0);
        exp_run = 1000;
`endif
        n_chk++;
        if (o_timeout || o_run != exp_run || o_busy != 31 + exp_run + 3) begin
            n_fail++;
            $display("FAIL long_run: timeout=%0d run=%0d busy=%0d required run %0d",
                     o_timeout, o_run, o_busy, exp_run);
        end
        n_chk++;
        if (pass !== 1'b1 || fail_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL long_run_result: pass=%b fail_idx=%0d required 1,2", pass, fail_idx);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_mismatch();
        test_start_during_run();
        test_reset_mid_clear();
        test_random();
        test_long_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_test_sequencer.md
CPU_TEST_SEQUENCER -- requirements
Module: cpu_test_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter REGS, default 32, register-file depth; entry 0 is never written.
REQ-003 SHALL have parameter RA_W, default 5, register address width, with REGS <= 2**RA_W.
REQ-004 SHALL have parameter MA_W, default 32, memory address width.
REQ-005 SHALL have parameter NCHK, default 2, number of memory check channels.
REQ-006 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1, one-cycle request to begin a test sequence.
REQ-009 SHALL have port run_cycles, input, 32, CPU run budget, sampled on accepted start.
REQ-010 SHALL have port chk_addr, input, NCHK*MA_W, flattened check addresses; channel k is in bits [k*MA_W +: MA_W].
REQ-011 SHALL have port chk_data, input, NCHK*WIDTH, flattened expected words; channel k is in bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port rf_we, output, 1, register-file write enable.
REQ-013 SHALL have port rf_waddr, output, RA_W, register-file write address.
REQ-014 SHALL have port rf_wdata, output, WIDTH, register-file write data; constant zero.
REQ-015 SHALL have port pc_hold, output, 1, forces the CPU PC to 0 while high.
REQ-016 SHALL have ports mem_re (output, 1), mem_addr (output, MA_W) and mem_rdata (input, WIDTH) for memory reads; read latency is exactly 1 cycle.
REQ-017 SHALL have ports busy, done, pass (outputs, 1 each) and fail_idx (output, clog2(NCHK)+1), which reports the first failing channel, or NCHK if all channels pass.

Function
REQ-018 SHALL implement FSM IDLE->CLEAR->RUN->CHECK->DONE; in DONE, start returns to CLEAR.
REQ-019 SHALL accept start only in IDLE or DONE; start in CLEAR/RUN/CHECK is ignored.
REQ-020 On accepted start: latch run_cycles and chk_*, clear done/pass, set fail_idx=NCHK, enter CLEAR.
REQ-021 In CLEAR: rf_we=1, pc_hold=1; rf_waddr steps 1..REGS-1, one address per cycle, over REGS-1 cycles; then go to RUN.
REQ-022 In RUN: pc_hold=0, rf_we=0; a 32-bit counter runs from 0; leave for CHECK after exactly run_cycles RUN cycles; run_cycles=0 leaves RUN after 1 cycle.
REQ-023 In CHECK: issue mem_re=1 with mem_addr=chk_addr[k] for k=0..NCHK-1, one per cycle; compare mem_rdata one cycle later against chk_data[k]; CHECK lasts NCHK+1 cycles.
REQ-024 On a mismatch: pass stays 0 at completion; fail_idx records the lowest mismatching k; later mismatches do not overwrite it.
REQ-025 In DONE: done=1; pass=1 only if all NCHK channels match; pc_hold=1; outputs hold until the next accepted start.
REQ-026 SHALL hold busy=1 exactly in CLEAR, RUN and CHECK.
REQ-027 Outside their active states, rf_we and mem_re SHALL be 0, and rf_waddr and mem_addr SHALL be 0.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately (asynchronously), from any state including mid-operation, force: state IDLE, all counters 0, rf_we=0, rf_waddr=0, rf_wdata=0, pc_hold=1, mem_re=0, mem_addr=0, busy=0, done=0, pass=0, fail_idx=NCHK.
REQ-029 On reset release, the block SHALL wait in IDLE for start; no write or read occurs without start.

Configuration
REQ-030 Macro CPU_SEQ_HALT_EN SHALL, when defined, add input cpu_halt (1 bit), sampled in RUN only; cpu_halt=1 ends RUN on the next edge, before the budget expires.
REQ-031 Without CPU_SEQ_HALT_EN: port cpu_halt SHALL be absent, and RUN SHALL end only on budget expiry.

Verification
REQ-032 Reset mid-CLEAR (rf_waddr=7): assert reset_n=0 -> same cycle rf_we=0, busy=0, pc_hold=1; after release, no writes without start.
REQ-033 REGS=32, start, run_cycles=10 -> rf_we high 31 cycles with rf_waddr 1..31; RUN exactly 10 cycles; pc_hold low only during those 10.
REQ-034 NCHK=2, chk_addr={0x2004,0x2000}, chk_data={5,3}, memory holds 3@0x2000, 5@0x2004 -> done=1, pass=1, fail_idx=2.
REQ-035 Same setup with memory 0x2000=4 and 0x2004=6 -> pass=0, fail_idx=0.
REQ-036 start pulsed again during RUN -> ignored; total sequence length unchanged (31+10+3 cycles).
REQ-037 With CPU_SEQ_HALT_EN, run_cycles=1000, cpu_halt=1 at RUN cycle 20 -> CHECK entered next cycle; without the macro, RUN lasts 1000 cycles.
